// File: rtl/ace_keymatrix_responder_if.sv
// Key-event handshake between a scancode translator (master) and the
// Jupiter Ace key-matrix responder (slave).
interface ace_keymatrix_responder_if;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] key_row;
  logic [2:0] key_col;
  logic       key_make;

  modport master (
    output key_valid,
    output key_row,
    output key_col,
    output key_make,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_row,
    input  key_col,
    input  key_make,
    output key_ready
  );
endinterface

// File: rtl/ace_keymatrix_responder.sv
// Keyboard side of the Jupiter Ace row/column matrix: 8x5 key state answered
// combinationally to CPU row selects, updated from a queued, rate-limited event stream.
module ace_keymatrix_responder #(
  parameter int unsigned HOLD_CYCLES = 65000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  ace_keymatrix_responder_if.slave  key,
  input  logic                      clear_all,
  input  logic [7:0]                filas,
  output logic [4:0]                columnas,
  output logic                      busy,
  output logic                      bad_event
);

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 5;
  localparam int unsigned CTR_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       make;
  } key_event_t;

  logic [1:0]                      state, state_nxt;
  logic [ROWS-1:0][COLS-1:0]       matrix;
  logic [CTR_W-1:0]                hold_ctr;
  key_event_t                      ev_q;
  key_event_t                      fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]                  wr_ptr, rd_ptr;
  logic                            fifo_empty, fifo_full;
  logic                            push_c, pop_c, apply_c, ctr_load_c, ctr_dec_c, bad_c;
  logic [COLS-1:0]                 col_pressed;
  key_event_t                      push_ev;

  // Queue status; the extra pointer bit separates full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign key.key_ready = ~fifo_full & ~clear_all;
  assign push_c        = key.key_valid & ~fifo_full & ~clear_all;
  assign push_ev       = '{row: key.key_row, col: key.key_col, make: key.key_make};

  assign busy      = (state != ST_IDLE) | ~fifo_empty;
  assign bad_event = bad_c;

  // Wired-AND column response: any selected (low) row pulls its pressed columns low.
  always_comb begin
    col_pressed = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (!filas[r]) col_pressed = col_pressed | matrix[r];
    end
  end
  assign columnas = ~col_pressed;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath strobes; clear_all overrides every decision.
  always_comb begin
    state_nxt  = state;
    pop_c      = 1'b0;
    apply_c    = 1'b0;
    ctr_load_c = 1'b0;
    ctr_dec_c  = 1'b0;
    bad_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (ev_q.col <= 3'd4) begin
          apply_c    = 1'b1;
          ctr_load_c = 1'b1;
          state_nxt  = ST_HOLD;
        end else begin
          bad_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_ctr == '0) state_nxt = ST_IDLE;
        else                ctr_dec_c = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear_all) begin
      state_nxt  = ST_IDLE;
      pop_c      = 1'b0;
      apply_c    = 1'b0;
      ctr_load_c = 1'b0;
      ctr_dec_c  = 1'b0;
      bad_c      = 1'b0;
    end
  end

  // Queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop_c)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Queue storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_ev;
  end

  // Event register, key matrix and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q     <= '0;
      matrix   <= '0;
      hold_ctr <= '0;
    end else if (clear_all) begin
      matrix   <= '0;
      hold_ctr <= '0;
    end else begin
      if (pop_c)      ev_q <= fifo_mem[rd_ptr[PTR_W-1:0]];
      if (apply_c)    matrix[ev_q.row][ev_q.col] <= ev_q.make;
      if (ctr_load_c) hold_ctr <= CTR_W'(HOLD_CYCLES - 1);
      else if (ctr_dec_c) hold_ctr <= hold_ctr - CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_ace_keymatrix_responder.sv
// Directed bench for ace_keymatrix_responder with HOLD_CYCLES=8, FIFO_DEPTH=4.
module tb_ace_keymatrix_responder;

  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_all;
  logic [7:0] filas;
  logic [4:0] columnas;
  logic       busy;
  logic       bad_event;

  int checks   = 0;
  int failures = 0;
  int bad_cnt  = 0;

  ace_keymatrix_responder_if kif ();

  ace_keymatrix_responder #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (kif),
    .clear_all (clear_all),
    .filas     (filas),
    .columnas  (columnas),
    .busy      (busy),
    .bad_event (bad_event)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bad_event) bad_cnt++;

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic       make;
    logic [7:0] probe;
    logic [4:0] exp_col;
    int         exp_wait;
    int         exp_bad;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push(input logic [2:0] row, input logic [2:0] col, input logic make);
    int n;
    kif.key_valid = 1'b1;
    kif.key_row   = row;
    kif.key_col   = col;
    kif.key_make  = make;
    n = 0;
    while (!kif.key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!kif.key_ready) check("push_timeout", 32'(kif.key_ready), 32'd1);
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, b0, pressed, busy_after;
    vecs[0] = '{3'd0, 3'd1, 1'b1, 8'hFE, 5'b11101, HOLD + 2, 0};
    vecs[1] = '{3'd3, 3'd4, 1'b1, 8'hF6, 5'b01101, HOLD + 2, 0};
    vecs[2] = '{3'd0, 3'd1, 1'b1, 8'hFD, 5'b11111, HOLD + 2, 0};
    vecs[3] = '{3'd0, 3'd1, 1'b0, 8'hFE, 5'b11111, HOLD + 2, 0};
    vecs[4] = '{3'd7, 3'd0, 1'b1, 8'h7F, 5'b11110, HOLD + 2, 0};
    vecs[5] = '{3'd2, 3'd6, 1'b1, 8'hFB, 5'b11111, 2,        1};
    vecs[6] = '{3'd2, 3'd2, 1'b1, 8'hFB, 5'b11011, HOLD + 2, 0};
    vecs[7] = '{3'd3, 3'd4, 1'b1, 8'h00, 5'b01010, HOLD + 2, 0};
    vecs[8] = '{3'd7, 3'd0, 1'b0, 8'hFF, 5'b11111, HOLD + 2, 0};

    reset         = 1'b1;
    clear_all     = 1'b0;
    filas         = 8'hFE;
    kif.key_valid = 1'b0;
    kif.key_row   = '0;
    kif.key_col   = '0;
    kif.key_make  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_columnas", 32'(columnas), 32'h1F);
    check("reset_ready", 32'(kif.key_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bad", 32'(bad_event), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First-event latency: matrix changes two edges after the handshake.
    push(3'd0, 3'd1, 1'b1);
    check("lat_e0", 32'(columnas), 32'h1F);
    @(negedge clk);
    check("lat_e1", 32'(columnas), 32'h1F);
    @(negedge clk);
    check("lat_e2", 32'(columnas), 32'b11101);
    filas = 8'hFD;
    #1 check("lat_other_row", 32'(columnas), 32'h1F);
    filas = 8'hFE;
    wait_idle(n);
    push(3'd0, 3'd1, 1'b0);
    wait_idle(n);
    check("lat_release", 32'(columnas), 32'h1F);

    // Back-to-back make/break: press visible for exactly HOLD+2 cycles.
    push(3'd0, 3'd1, 1'b1);
    push(3'd0, 3'd1, 1'b0);
    pressed    = 0;
    busy_after = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (columnas == 5'b11101) pressed++;
      else if (pressed > 0 && busy) busy_after++;
    end
    check("b2b_press_len", 32'(pressed), 32'(HOLD + 2));
    check("b2b_busy_tail", 32'(busy_after), 32'(HOLD));
    check("b2b_final_col", 32'(columnas), 32'h1F);
    check("b2b_final_busy", 32'(busy), 32'd0);

    // Table-driven single events.
    for (int i = 0; i < 9; i++) begin
      b0 = bad_cnt;
      push(vecs[i].row, vecs[i].col, vecs[i].make);
      wait_idle(n);
      check($sformatf("vec%0d_wait", i), 32'(n), 32'(vecs[i].exp_wait));
      check($sformatf("vec%0d_bad", i), 32'(bad_cnt - b0), 32'(vecs[i].exp_bad));
      filas = vecs[i].probe;
      #1 check($sformatf("vec%0d_col", i), 32'(columnas), 32'(vecs[i].exp_col));
      @(negedge clk);
    end

    // Overflow: six events, the queue fills while the first is held.
    filas = 8'hFF;
    push(3'd1, 3'd0, 1'b1);
    push(3'd2, 3'd1, 1'b1);
    push(3'd4, 3'd2, 1'b1);
    push(3'd5, 3'd3, 1'b1);
    push(3'd6, 3'd4, 1'b1);
    check("ovf_ready_low", 32'(kif.key_ready), 32'd0);
    push(3'd1, 3'd0, 1'b0);
    wait_idle(n);
    filas = 8'hFD; #1 check("ovf_row1", 32'(columnas), 32'b11111);
    filas = 8'hFB; #1 check("ovf_row2", 32'(columnas), 32'b11001);
    filas = 8'hF7; #1 check("ovf_row3", 32'(columnas), 32'b01111);
    filas = 8'hEF; #1 check("ovf_row4", 32'(columnas), 32'b11011);
    filas = 8'hDF; #1 check("ovf_row5", 32'(columnas), 32'b10111);
    filas = 8'hBF; #1 check("ovf_row6", 32'(columnas), 32'b01111);
    @(negedge clk);

    // clear_all mid-HOLD with three events queued.
    filas = 8'hFE;
    push(3'd0, 3'd0, 1'b1);
    push(3'd0, 3'd1, 1'b1);
    push(3'd0, 3'd2, 1'b1);
    push(3'd0, 3'd3, 1'b1);
    clear_all = 1'b1;
    #1 check("clr_ready_low", 32'(kif.key_ready), 32'd0);
    check("clr_busy_before", 32'(busy), 32'd1);
    check("clr_col_before", 32'(columnas), 32'b11110);
    @(negedge clk);
    clear_all = 1'b0;
    filas = 8'h00;
    #1 check("clr_busy_after", 32'(busy), 32'd0);
    check("clr_col_after", 32'(columnas), 32'h1F);
    check("clr_ready_after", 32'(kif.key_ready), 32'd1);
    repeat (30) @(negedge clk);
    check("clr_busy_later", 32'(busy), 32'd0);
    check("clr_col_later", 32'(columnas), 32'h1F);

    // Asynchronous reset in the middle of a hold.
    filas = 8'hFE;
    push(3'd0, 3'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_pre_col", 32'(columnas), 32'b11110);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_col", 32'(columnas), 32'h1F);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_ready", 32'(kif.key_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_after_col", 32'(columnas), 32'h1F);
    check("rst_after_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ace_keymatrix_responder.md
Name: ace_keymatrix_responder

Overview:
- Keyboard-side end of the Jupiter Ace row/column matrix interface. The CPU drives the rows (filas, address bits 15:8) and samples the columns (columnas, 5 bits, active-low).
- This block holds an 8x5 key-state matrix and answers any row select with the column pattern of the pressed keys.
- The matrix is updated from a queued key-event stream, for example a PS/2 scancode translator. Each applied event is held for a minimum time so the Ace ROM scan sees every make and break, however fast the host sends them.

Parameters:
- HOLD_CYCLES, 65000: minimum clk cycles between consecutive applied events (10 ms at 6.5 MHz). Must be >= 1.
- FIFO_DEPTH, 4: key-event queue depth. Power of 2, >= 2.

Ports:
- clk, input, 1: system clock (same domain as the CPU clock enables).
- reset, input, 1: asynchronous, active-high reset.
- key_valid, input, 1: key event present.
- key_ready, output, 1: block can accept an event. Event is accepted when key_valid and key_ready are both high on a clk rising edge.
- key_row, input, 3: matrix row 0..7.
- key_col, input, 3: matrix column; 0..4 valid, 5..7 invalid.
- key_make, input, 1: 1 = press, 0 = release.
- clear_all, input, 1: release all keys and flush the queue.
- filas, input, 8: row selects from the CPU, active-low.
- columnas, output, 5: column response, active-low.
- busy, output, 1: queue not empty or FSM not IDLE.
- bad_event, output, 1: one-cycle pulse when an event with key_col > 4 is popped.

Behaviour:
- Reset values: matrix all 0; FIFO empty; state IDLE; hold counter 0; bad_event 0; busy 0; key_ready 1; columnas 5'b11111.
- columnas[c] is combinational from filas and the registered matrix: columnas[c] = ~(OR over r of (~filas[r] & matrix[r][c])).
  - Several rows low: the responses are ANDed (wired-AND behaviour).
  - filas = 8'hFF: output is 5'b11111.
  - There is no clock latency from filas to columnas.
- FIFO:
  - key_ready = ~full & ~clear_all.
  - Push of {row, col, make} on handshake.
  - A simultaneous push and pop when not full are both honoured. Count stays the same.
  - No push is possible when full; the source must stall.
- FSM, states IDLE, APPLY, HOLD:
  - IDLE: if FIFO not empty, pop the head into an event register and go to APPLY next cycle.
  - APPLY, single cycle:
    - key_col <= 4: matrix[row][col] <= make, load the hold counter with HOLD_CYCLES-1, go to HOLD.
    - key_col > 4: matrix unchanged, bad_event = 1 for this cycle, go to IDLE. No hold is applied.
  - HOLD: decrement the counter each cycle. Go to IDLE in the cycle after the counter reads 0.
- Minimum spacing: the matrix changes of two consecutive valid events are at least HOLD_CYCLES+2 cycles apart.
- A make for a key that is already pressed, or a break for a key that is already released, is still applied as a no-op write and still consumes a full hold.
- clear_all is synchronous, sampled at the clk edge, and has priority over everything else:
  - matrix <= 0, FIFO flushed, state <= IDLE, counter <= 0.
  - No push is accepted in that cycle.
  - An event in APPLY in that cycle is discarded.
- Asynchronous reset mid-HOLD or mid-APPLY returns to the reset values immediately. columnas goes to 5'b11111 combinationally with the cleared matrix.
- Hold counter width is clog2(HOLD_CYCLES+1). It does not wrap: it is loaded only in APPLY.
- busy = (state != IDLE) | ~empty.

Test Plan:
- Reset, then filas = 8'hFE -> columnas = 5'b11111, key_ready = 1, busy = 0.
- Push make row 0 col 1 (HOLD_CYCLES = 8) -> matrix bit set 2 cycles after the handshake; filas = 8'hFE -> columnas = 5'b11101; filas = 8'hFD -> columnas = 5'b11111.
- Push make (0,1) and break (0,1) back-to-back -> press visible for exactly 10 cycles (HOLD_CYCLES+2), then columnas returns to 5'b11111; busy drops after the second hold ends.
- Press (0,1) and (3,4); filas = 8'hF6 -> columnas = 5'b01101.
- Push 5 events while the first is in HOLD (FIFO_DEPTH = 4) -> key_ready low once 4 are queued; no event is lost; all are applied in order.
- Push row 2 col 6 -> bad_event pulses one cycle, no hold, matrix unchanged.
- Assert clear_all mid-HOLD with 3 queued events -> columnas 5'b11111 for every filas; busy = 0 next cycle; key_ready low during clear_all.
